// File: rtl/inst_merge_pkg.sv
// inst_merge_pkg: shared widths, merge entry type and pID increment helper
package inst_merge_pkg;
  localparam int DATA_W = 32;
  localparam int PID_W = 2;
  localparam int SLOTS = 2 ** PID_W;
  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [DATA_W-1:0] addr;
    logic [PID_W-1:0] pid;
  } merge_entry_t;
  function automatic logic [PID_W-1:0] pid_next(input logic [PID_W-1:0] p);
    return PID_W'(p + 1'b1);
  endfunction
endpackage

// File: rtl/inst_order_merge_if.sv
// inst_order_merge_if: fetch-way inputs, flush and decode-side stream of the merge
interface inst_order_merge_if;
  import inst_merge_pkg::*;
  logic way0_valid_i;
  logic [DATA_W-1:0] way0_inst_i;
  logic [DATA_W-1:0] way0_addr_i;
  logic [PID_W-1:0] way0_pid_i;
  logic way0_ready_o;
  logic way1_valid_i;
  logic [DATA_W-1:0] way1_inst_i;
  logic [DATA_W-1:0] way1_addr_i;
  logic [PID_W-1:0] way1_pid_i;
  logic way1_ready_o;
  logic flush_i;
  logic [PID_W-1:0] flush_pid_i;
  logic valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [DATA_W-1:0] instAddr_o;
  logic [PID_W-1:0] pid_o;
  logic ready_i;
  logic err_o;
  modport master (
    output way0_valid_i, way0_inst_i, way0_addr_i, way0_pid_i,
    output way1_valid_i, way1_inst_i, way1_addr_i, way1_pid_i,
    output flush_i, flush_pid_i, ready_i,
    input way0_ready_o, way1_ready_o, valid_o, inst_o, instAddr_o, pid_o, err_o
  );
  modport slave (
    input way0_valid_i, way0_inst_i, way0_addr_i, way0_pid_i,
    input way1_valid_i, way1_inst_i, way1_addr_i, way1_pid_i,
    input flush_i, flush_pid_i, ready_i,
    output way0_ready_o, way1_ready_o, valid_o, inst_o, instAddr_o, pid_o, err_o
  );
endinterface

// File: rtl/merge_out_reg.sv
// merge_out_reg: single-entry valid/ready output register with hold, load and flush-clear
module merge_out_reg
  import inst_merge_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         flush,
  input  logic         ready,
  input  merge_entry_t d,
  output logic         valid,
  output merge_entry_t q
);
  // flush drops the held entry; otherwise load replaces it or a consumed entry empties the register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      q <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/inst_order_merge.sv
// inst_order_merge: re-sequences even/odd fetch ways into one in-order stream for decode
module inst_order_merge
  import inst_merge_pkg::*;
(
  input logic clk,
  input logic reset_n,
  inst_order_merge_if.slave m
);
  logic [DATA_W-1:0] inst_q [SLOTS];
  logic [DATA_W-1:0] addr_q [SLOTS];
  logic [SLOTS-1:0] occ_q, occ_nxt;
  logic [PID_W-1:0] exp_q;
  logic err_q;
  logic acc0, acc1, wr0, wr1, err_set, load, out_valid;
  merge_entry_t head, out_q;
  assign m.way0_ready_o = !(occ_q[0] && occ_q[2]);
  assign m.way1_ready_o = !(occ_q[1] && occ_q[3]);
  assign acc0 = m.way0_valid_i && m.way0_ready_o && !m.flush_i;
  assign acc1 = m.way1_valid_i && m.way1_ready_o && !m.flush_i;
  assign wr0 = acc0 && !m.way0_pid_i[0];
  assign wr1 = acc1 && m.way1_pid_i[0];
  assign load = occ_q[exp_q] && (!out_valid || m.ready_i) && !m.flush_i;
  assign head = '{inst: inst_q[exp_q], addr: addr_q[exp_q], pid: exp_q};
  // wrong-parity entries and overwrites of a live slot (one not draining this edge) are errors
  always_comb begin
    err_set = (acc0 && m.way0_pid_i[0]) || (acc1 && !m.way1_pid_i[0]);
    err_set = err_set || (wr0 && occ_q[m.way0_pid_i] && !(load && exp_q == m.way0_pid_i));
    err_set = err_set || (wr1 && occ_q[m.way1_pid_i] && !(load && exp_q == m.way1_pid_i));
  end
  // drain clears the head slot, writes set theirs, flush empties everything
  always_comb begin
    occ_nxt = occ_q;
    if (load) occ_nxt[exp_q] = 1'b0;
    if (wr0) occ_nxt[m.way0_pid_i] = 1'b1;
    if (wr1) occ_nxt[m.way1_pid_i] = 1'b1;
    if (m.flush_i) occ_nxt = '0;
  end
  // slot payloads need no reset; occupancy decides whether they are meaningful
  always_ff @(posedge clk) begin
    if (wr0) begin
      inst_q[m.way0_pid_i] <= m.way0_inst_i;
      addr_q[m.way0_pid_i] <= m.way0_addr_i;
    end
    if (wr1) begin
      inst_q[m.way1_pid_i] <= m.way1_inst_i;
      addr_q[m.way1_pid_i] <= m.way1_addr_i;
    end
  end
  // occupancy, expected pID pointer and sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      occ_q <= occ_nxt;
      exp_q <= m.flush_i ? m.flush_pid_i : load ? pid_next(exp_q) : exp_q;
      err_q <= err_q || err_set;
    end
  end
  merge_out_reg u_out (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .flush   (m.flush_i),
    .ready   (m.ready_i),
    .d       (head),
    .valid   (out_valid),
    .q       (out_q)
  );
  assign m.valid_o = out_valid;
  assign m.inst_o = out_q.inst;
  assign m.instAddr_o = out_q.addr;
  assign m.pid_o = out_q.pid;
  assign m.err_o = err_q;
endmodule

// File: tb/tb_inst_order_merge.sv
// tb_inst_order_merge: directed stimulus with a reorder model and per-cycle comparison
module tb_inst_order_merge;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  inst_order_merge_if bus();
  inst_order_merge dut (.clk(clk), .reset_n(reset_n), .m(bus));
  always #5 clk = ~clk;

  // reference: slots by pID, next pID owed to decode, one-entry output stage
  int mo [4];
  logic [31:0] mi [4];
  logic [31:0] ma [4];
  int mexp, mop;
  bit mv, merr;
  logic [31:0] moi, moa;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mo = '{default: 0};
      mexp = 0; mv = 0; moi = 0; moa = 0; mop = 0; merr = 0;
    end else if (bus.flush_i) begin
      mo = '{default: 0};
      mv = 0;
      mexp = int'(bus.flush_pid_i);
    end else begin : upd
      bit r0, r1, take;
      int p;
      r0 = (mo[0] + mo[2]) < 2;
      r1 = (mo[1] + mo[3]) < 2;
      take = mo[mexp] == 1 && (!mv || bus.ready_i);
      if (take) begin
        mv = 1; moi = mi[mexp]; moa = ma[mexp]; mop = mexp;
        mo[mexp] = 0;
        mexp = (mexp + 1) % 4;
      end else if (bus.ready_i) mv = 0;
      if (bus.way0_valid_i && r0) begin
        p = int'(bus.way0_pid_i);
        if (p % 2 == 1) merr = 1;
        else begin
          if (mo[p] == 1) merr = 1;
          mi[p] = bus.way0_inst_i; ma[p] = bus.way0_addr_i; mo[p] = 1;
        end
      end
      if (bus.way1_valid_i && r1) begin
        p = int'(bus.way1_pid_i);
        if (p % 2 == 0) merr = 1;
        else begin
          if (mo[p] == 1) merr = 1;
          mi[p] = bus.way1_inst_i; ma[p] = bus.way1_addr_i; mo[p] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_valid", 32'(bus.valid_o), 32'(mv));
    if (mv) begin
      chk("m_inst", bus.inst_o, moi);
      chk("m_addr", bus.instAddr_o, moa);
      chk("m_pid", 32'(bus.pid_o), 32'(mop));
    end
    chk("m_w0_ready", 32'(bus.way0_ready_o), 32'((mo[0] + mo[2]) < 2));
    chk("m_w1_ready", 32'(bus.way1_ready_o), 32'((mo[1] + mo[3]) < 2));
    chk("m_err", 32'(bus.err_o), 32'(merr));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic w0(input bit v, input int p, input logic [31:0] i);
    bus.way0_valid_i = v; bus.way0_pid_i = 2'(p);
    bus.way0_inst_i = i; bus.way0_addr_i = i + 32'h1000;
  endtask

  task automatic w1(input bit v, input int p, input logic [31:0] i);
    bus.way1_valid_i = v; bus.way1_pid_i = 2'(p);
    bus.way1_inst_i = i; bus.way1_addr_i = i + 32'h1000;
  endtask

  task automatic do_flush(input int p);
    bus.flush_i = 1; bus.flush_pid_i = 2'(p);
    cyc();
    bus.flush_i = 0;
  endtask

  task automatic out_is(input string nm, input int p, input logic [31:0] i);
    chk({nm, "_valid"}, 32'(bus.valid_o), 1);
    chk({nm, "_pid"}, 32'(bus.pid_o), 32'(p));
    chk({nm, "_inst"}, bus.inst_o, i);
    chk({nm, "_addr"}, bus.instAddr_o, i + 32'h1000);
  endtask

  initial begin
    w0(0, 0, 0); w1(0, 1, 0);
    bus.flush_i = 0; bus.flush_pid_i = 0; bus.ready_i = 1;
    repeat (2) cyc();
    chk("rst_valid", 32'(bus.valid_o), 0);
    chk("rst_inst", bus.inst_o, 0);
    chk("rst_err", 32'(bus.err_o), 0);
    chk("rst_w0r", 32'(bus.way0_ready_o), 1);
    chk("rst_w1r", 32'(bus.way1_ready_o), 1);
    reset_n = 1;
    cyc();
    // in order, one cycle apart
    w0(1, 0, 32'h100); cyc();
    chk("io_lat", 32'(bus.valid_o), 0);
    w0(0, 0, 0); w1(1, 1, 32'h101); cyc();
    out_is("io_0", 0, 32'h100);
    w1(0, 1, 0); cyc();
    out_is("io_1", 1, 32'h101);
    cyc();
    chk("io_idle", 32'(bus.valid_o), 0);
    // out of order: pID1 three edges ahead of pID0
    do_flush(0);
    w1(1, 1, 32'h11); cyc();
    w1(0, 1, 0); cyc(); cyc();
    chk("ooo_wait", 32'(bus.valid_o), 0);
    w0(1, 0, 32'h00); cyc();
    chk("ooo_bypass", 32'(bus.valid_o), 0);
    w0(0, 0, 0); cyc();
    out_is("ooo_0", 0, 32'h00);
    cyc();
    out_is("ooo_1", 1, 32'h11);
    cyc();
    chk("ooo_idle", 32'(bus.valid_o), 0);
    // back-pressure with every slot filled, then drain and wrap
    do_flush(0);
    bus.ready_i = 0;
    w0(1, 2, 32'h202); w1(1, 1, 32'h201); cyc();
    w0(1, 0, 32'h200); w1(1, 3, 32'h203); cyc();
    chk("bp_w0r_full", 32'(bus.way0_ready_o), 0);
    chk("bp_w1r_full", 32'(bus.way1_ready_o), 0);
    chk("bp_nv", 32'(bus.valid_o), 0);
    w0(0, 0, 0); w1(0, 1, 0); cyc();
    out_is("bp_h0", 0, 32'h200);
    chk("bp_w0r_free", 32'(bus.way0_ready_o), 1);
    cyc();
    out_is("bp_h1", 0, 32'h200);
    bus.ready_i = 1; cyc();
    out_is("bp_1", 1, 32'h201);
    cyc();
    out_is("bp_2", 2, 32'h202);
    cyc();
    out_is("bp_3", 3, 32'h203);
    cyc();
    chk("bp_empty", 32'(bus.valid_o), 0);
    w0(1, 0, 32'h210); cyc();
    w0(0, 0, 0); cyc();
    out_is("bp_wrap", 0, 32'h210);
    cyc();
    // flush discards a held output and both slots, realigns to pID2
    do_flush(0);
    bus.ready_i = 0;
    w0(1, 0, 32'h400); w1(1, 1, 32'h401); cyc();
    w0(1, 2, 32'h402); w1(0, 1, 0); cyc();
    out_is("fl_held", 0, 32'h400);
    w0(1, 0, 32'h4ff);
    do_flush(2);
    w0(0, 0, 0);
    chk("fl_valid", 32'(bus.valid_o), 0);
    chk("fl_w0r", 32'(bus.way0_ready_o), 1);
    bus.ready_i = 1;
    w0(1, 2, 32'h422); cyc();
    chk("fl_lat", 32'(bus.valid_o), 0);
    w0(0, 0, 0); cyc();
    out_is("fl_first", 2, 32'h422);
    cyc();
    chk("fl_idle", 32'(bus.valid_o), 0);
    // wrong parity is dropped and the error survives a flush
    chk("er_clean", 32'(bus.err_o), 0);
    do_flush(0);
    w0(1, 1, 32'hbad); cyc();
    chk("er_parity", 32'(bus.err_o), 1);
    w0(1, 0, 32'h500); cyc();
    w0(0, 0, 0); cyc();
    out_is("er_p0", 0, 32'h500);
    cyc();
    chk("er_dropped", 32'(bus.valid_o), 0);
    do_flush(2);
    chk("er_sticky", 32'(bus.err_o), 1);
    // asynchronous reset while an entry is held
    bus.ready_i = 0;
    w0(1, 2, 32'h602); cyc();
    w0(0, 0, 0); cyc();
    chk("ar_pre", 32'(bus.valid_o), 1);
    #2 reset_n = 0;
    #1;
    chk("ar_valid", 32'(bus.valid_o), 0);
    chk("ar_inst", bus.inst_o, 0);
    chk("ar_addr", bus.instAddr_o, 0);
    chk("ar_pid", 32'(bus.pid_o), 0);
    chk("ar_err", 32'(bus.err_o), 0);
    chk("ar_w0r", 32'(bus.way0_ready_o), 1);
    chk("ar_w1r", 32'(bus.way1_ready_o), 1);
    cyc(); cyc();
    reset_n = 1; bus.ready_i = 1;
    // after reset pID0 flows, and a second write to live pID3 is an error
    w0(1, 0, 32'h300); w1(1, 3, 32'h303); cyc();
    chk("co_first", 32'(bus.err_o), 0);
    w0(0, 0, 0); w1(1, 3, 32'h3033); cyc();
    chk("co_err", 32'(bus.err_o), 1);
    out_is("co_p0", 0, 32'h300);
    w0(1, 2, 32'h302); w1(1, 1, 32'h301); cyc();
    chk("co_gap", 32'(bus.valid_o), 0);
    w0(0, 0, 0); w1(0, 1, 0); cyc();
    out_is("co_p1", 1, 32'h301);
    cyc();
    out_is("co_p2", 2, 32'h302);
    cyc();
    out_is("co_p3_newest", 3, 32'h3033);
    cyc();
    chk("co_idle", 32'(bus.valid_o), 0);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_order_merge.md
Name: inst_order_merge

Overview:
- Sits directly downstream of the two fetch ways (way0 carries even pIDs, way1 carries odd pIDs) and upstream of decode.
- Accepts fetched instruction/address pairs from both ways, each tagged with a 2-bit program-order ID (pID).
- Re-sequences them into strict program order and presents one registered valid/ready stream to decode.
- On a jump/redirect flush it discards everything it holds and realigns to a new starting pID.

Parameters:
- DATA_W, 32, instruction and address width.
- SLOTS, 4, reorder slots; fixed at 2**PID_W.
- PID_W, 2, pID width; slot index = pID.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- way0_valid_i  in  1  way0 entry present this cycle
- way0_inst_i  in  DATA_W  way0 instruction
- way0_addr_i  in  DATA_W  way0 instruction address
- way0_pid_i  in  PID_W  way0 pID (even)
- way0_ready_o  out  1  merge can accept a way0 entry
- way1_valid_i / way1_inst_i / way1_addr_i / way1_pid_i / way1_ready_o  same for way1 (odd pIDs)
- flush_i  in  1  jump/redirect; discard all held entries
- flush_pid_i  in  PID_W  pID of the first instruction after redirect
- valid_o  out  1  output entry valid
- inst_o  out  DATA_W  output instruction
- instAddr_o  out  DATA_W  output address
- pid_o  out  PID_W  output pID
- ready_i  in  1  decode accepts the output
- err_o  out  1  sticky protocol error

Behaviour:
- Reset values:
  - valid_o=0, inst_o=0, instAddr_o=0, pid_o=0, err_o=0.
  - All slot-occupied bits 0; expected pointer exp=0.
  - way0_ready_o=1, way1_ready_o=1 (combinational from slot state).
- Slot store: SLOTS entries of {inst, addr, occ}, indexed by pID.
- Accept rule:
  - wayN is accepted when wayN_valid_i && wayN_ready_o && !flush_i; the slot at wayN_pid_i is written and occ set at that edge.
  - way0_ready_o = fewer than 2 even slots occupied; way1_ready_o = fewer than 2 odd slots occupied.
  - Both ways may be accepted in the same cycle (they always target different slots by parity).
- Parity check: a way0 entry with pID[0]=1, or a way1 entry with pID[0]=0, is dropped (not written) and sets err_o.
- Collision: accepting into a slot whose occ=1 (and which is not being drained that cycle) sets err_o; the write still happens (newest wins).
- Output register:
  - Loaded when slot[exp].occ=1 and (valid_o=0 or ready_i=1).
  - Load copies inst/addr/pID to the outputs, sets valid_o=1, clears slot[exp].occ and increments exp modulo SLOTS (wrap 3->0).
  - If valid_o && ready_i and nothing is loadable, valid_o clears next cycle.
  - Outputs are held stable while valid_o && !ready_i.
- Latency:
  - An entry accepted at edge N that is at exp, with the output register free, appears on valid_o after edge N+1.
  - Sustained throughput is 1 entry/cycle.
- Same-slot bypass: an entry written into slot[exp] cannot be loaded at the same edge; it loads at the following edge.
- Flush:
  - flush_i has priority over every other event in that cycle.
  - At the edge: all occ cleared, valid_o=0, exp=flush_pid_i, inputs ignored that cycle; err_o unaffected.
  - Flush while valid_o && !ready_i discards the held output.
- Ordering: entries with pID != exp wait in their slot; decode never sees an out-of-order pID.
- Reset mid-operation: asynchronous return to the reset values above, regardless of state.
- err_o clears only on reset.

Decomposition:
- Package inst_merge_pkg holds:
  - constants PID_W and SLOTS;
  - typedef merge_entry_t {inst, addr, pid};
  - function pid_next(pid) for modulo increment.
- One natural sub-module: merge_out_reg, a single-entry valid/ready output register with hold, load and flush-clear.
- The slot array and pointer logic stay in the top level.

Test Plan:
- In-order: after reset, way0 sends pID0 then way1 sends pID1 one cycle apart, ready_i=1 -> output pIDs 0,1 on consecutive cycles with matching inst/addr; the first valid_o appears 1 cycle after acceptance.
- Out-of-order: way1 pID1 (inst 0x11) accepted 3 cycles before way0 pID0 (inst 0x00) -> valid_o stays 0 until pID0 arrives, then 0x00 followed by 0x11 on consecutive cycles.
- Back-pressure: ready_i=0 with pIDs 0–3 all arrived -> valid_o=1 holds pID0 stable; way0_ready_o=0 after even slots 2 fill; releasing ready_i drains 0,1,2,3 then wraps to expect 0.
- Flush: slots hold pID1 and pID2, output holds pID0 with ready_i=0; flush_i with flush_pid_i=2 -> next cycle valid_o=0, all slots empty, exp=2; a subsequent way0 pID2 is output first.
- Errors: way0 presents pID1 -> entry dropped, err_o=1 and stays 1 through a flush; a second write to an occupied pID3 slot also sets err_o.
- Async reset asserted mid-stream while valid_o=1 -> all outputs 0 immediately and ready outputs 1; after release the first accepted pID0 flows normally.
